// File: rtl/hdlc_tx_pkg.sv
// Shared types and constants for the HDLC transmit frame loader.
// The optional frame counter is enabled by defining HDLC_TX_FRMCNT_EN.
package hdlc_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        START = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } tx_state_e;

    localparam int unsigned MAX_LEN = 512;
    localparam int unsigned IRQ_W   = 8;

    // Bit positions inside the sticky error vector.
    localparam int ERR_BUSY = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_TO   = 2;

    // A frame may be launched only with 1..MAX_LEN bytes.
    function automatic logic len_valid(input logic [9:0] len);
        return (len != 10'd0) && (len <= 10'(MAX_LEN));
    endfunction

endpackage

// File: rtl/hdlc_tx_frame_ram.sv
// 512x8 frame buffer: word-wide writes land as two bytes (even = low byte,
// odd = high byte) in one cycle; byte-wide reads with one cycle of latency.
// Split into two 256x8 banks so each bank sees at most one write per cycle.
module hdlc_tx_frame_ram (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic [7:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic        re_i,
    input  logic [8:0]  raddr_i,
    output logic [7:0]  rdata_o
);

    logic [7:0] mem_lo [256];
    logic [7:0] mem_hi [256];
    logic [7:0] rdata_q;

    // Word write: low byte to the even bank, high byte to the odd bank.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_lo[waddr_i] <= wdata_i[7:0];
            mem_hi[waddr_i] <= wdata_i[15:8];
        end
    end

    // Registered byte read; the output register resets so ramd is 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= raddr_i[0] ? mem_hi[raddr_i[8:1]] : mem_lo[raddr_i[8:1]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hdlc_tx_frame_loader.sv
// EMIF-side transmit frame loader: buffers a frame written by the DSP,
// launches the HDLC transmitter on GO and serves bytes on tx_rd requests.
// Define HDLC_TX_FRMCNT_EN to build the completed-frame counter (frm_cnt);
// without it frm_cnt is tied to zero.
//
// Transmitter byte handshake: tx_rd is a one-cycle request; the requested
// byte appears on ramd exactly one cycle later and stays until the next
// request. Requests past the end of the frame return 8'h00.
module hdlc_tx_frame_loader
    import hdlc_tx_pkg::*;
#(
    parameter logic [23:0] BUF_BASE = 24'h000000,
    parameter logic [23:0] REG_LEN  = 24'h000100,
    parameter logic [23:0] REG_GO   = 24'h000101,
    parameter logic [23:0] TIMEOUT  = 24'd8000000
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [23:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        tx_rd,
    input  logic        tx_done,
    output logic        trastart_flag,
    output logic [9:0]  db,
    output logic [7:0]  ramd,
    output logic        busy,
    output logic        irq,
    output logic [2:0]  err,
    output logic [15:0] frm_cnt,
    output tx_state_e   dbg_state_o
);

    tx_state_e   state_q, state_d;
    logic [9:0]  len_q, len_d;
    logic [9:0]  db_q, db_d;
    logic [9:0]  rd_ptr_q, rd_ptr_d;
    logic        zero_q, zero_d;
    logic [23:0] to_cnt_q, to_cnt_d;
    logic [3:0]  irq_cnt_q, irq_cnt_d;
    logic [2:0]  err_q, err_d;

    logic [23:0] buf_off;
    logic        buf_hit, len_hit, go_hit;
    logic        go_req, clr_req, go_ok;
    logic        in_frame;
    logic        done_ev, to_hit, rd_ev, rd_in_range;
    logic        ram_we, ram_re;
    logic [8:0]  ram_raddr;
    logic [7:0]  ram_rdata;

    // Address decode; subtraction wraps addresses below BUF_BASE out of range.
    assign buf_off     = wr_addr - BUF_BASE;
    assign buf_hit     = wr_en && (buf_off < 24'd256);
    assign len_hit     = wr_en && (wr_addr == REG_LEN);
    assign go_hit      = wr_en && (wr_addr == REG_GO);
    assign go_req      = go_hit && wr_data[0];
    assign clr_req     = go_hit && wr_data[1];
    assign in_frame    = (state_q != IDLE);
    assign go_ok       = go_req && !in_frame && len_valid(len_q);

    // SEND-state events: tx_done beats the timeout, both beat a byte request.
    assign done_ev     = (state_q == SEND) && tx_done;
    assign to_hit      = (state_q == SEND) && !tx_done && (to_cnt_q == TIMEOUT - 24'd1);
    assign rd_ev       = (state_q == SEND) && tx_rd && !tx_done && !to_hit;
    assign rd_in_range = (rd_ptr_q < len_q);

    // FSM state register.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go_ok) state_d = ARM;
            ARM:     state_d = START;
            START:   state_d = SEND;
            SEND:    if (done_ev || to_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        trastart_flag = (state_q == START);
        busy          = in_frame;
        dbg_state_o   = state_q;
    end

    // Datapath next-state: registers, buffer access, pointers, errors, irq.
    always_comb begin
        len_d     = len_q;
        db_d      = db_q;
        rd_ptr_d  = rd_ptr_q;
        zero_d    = zero_q;
        to_cnt_d  = to_cnt_q;
        irq_cnt_d = irq_cnt_q;
        err_d     = err_q;
        ram_we    = buf_hit && !in_frame;
        ram_re    = 1'b0;
        ram_raddr = 9'd0;

        if (len_hit && !in_frame) len_d = wr_data[9:0];
        if (go_ok)                db_d  = len_q;

        // Clear first, then any new error from this cycle.
        if (clr_req) err_d = 3'b000;
        if ((buf_hit || len_hit || go_req) && in_frame) err_d[ERR_BUSY] = 1'b1;
        if (go_req && !in_frame && !len_valid(len_q))   err_d[ERR_LEN]  = 1'b1;
        if (to_hit)                                     err_d[ERR_TO]   = 1'b1;

        case (state_q)
            ARM: begin
                ram_re = 1'b1;
                zero_d = 1'b0;
            end
            START: begin
                rd_ptr_d = 10'd1;
                to_cnt_d = 24'd0;
            end
            SEND: begin
                to_cnt_d = to_cnt_q + 24'd1;
                if (rd_ev) begin
                    if (rd_in_range) begin
                        ram_re    = 1'b1;
                        ram_raddr = rd_ptr_q[8:0];
                        rd_ptr_d  = rd_ptr_q + 10'd1;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // The completion pulse runs on its own, independent of later launches.
        if (done_ev || to_hit)      irq_cnt_d = 4'(IRQ_W);
        else if (irq_cnt_q != 4'd0) irq_cnt_d = irq_cnt_q - 4'd1;
    end

    // Datapath registers.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= 10'd0;
            db_q      <= 10'd0;
            rd_ptr_q  <= 10'd0;
            zero_q    <= 1'b0;
            to_cnt_q  <= 24'd0;
            irq_cnt_q <= 4'd0;
            err_q     <= 3'b000;
        end else begin
            len_q     <= len_d;
            db_q      <= db_d;
            rd_ptr_q  <= rd_ptr_d;
            zero_q    <= zero_d;
            to_cnt_q  <= to_cnt_d;
            irq_cnt_q <= irq_cnt_d;
            err_q     <= err_d;
        end
    end

`ifdef HDLC_TX_FRMCNT_EN
    logic [15:0] frm_q, frm_d;

    // Completed-frame counter: clear first, then count a tx_done completion.
    always_comb begin
        frm_d = frm_q;
        if (clr_req) frm_d = 16'h0000;
        if (done_ev) frm_d = frm_d + 16'h0001;
    end

    // Frame counter register.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) frm_q <= 16'h0000;
        else        frm_q <= frm_d;
    end

    assign frm_cnt = frm_q;
`else
    assign frm_cnt = 16'h0000;
`endif

    hdlc_tx_frame_ram u_ram (
        .clk_i   (clk_100m),
        .rst_n_i (rst_n),
        .we_i    (ram_we),
        .waddr_i (buf_off[7:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign db   = db_q;
    assign ramd = zero_q ? 8'h00 : ram_rdata;
    assign irq  = (irq_cnt_q != 4'd0);
    assign err  = err_q;

endmodule

// File: tb/tb_hdlc_tx_frame_loader.sv
// Directed bench for hdlc_tx_frame_loader (TIMEOUT shortened to 100 cycles).
module tb_hdlc_tx_frame_loader;
    import hdlc_tx_pkg::*;

    localparam logic [23:0] A_BUF = 24'h000000;
    localparam logic [23:0] A_LEN = 24'h000100;
    localparam logic [23:0] A_GO  = 24'h000101;

    logic        clk_100m = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        tx_rd;
    logic        tx_done;
    logic        trastart_flag;
    logic [9:0]  db;
    logic [7:0]  ramd;
    logic        busy;
    logic        irq;
    logic [2:0]  err;
    logic [15:0] frm_cnt;
    tx_state_e   dbg_state;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_frm = 16'h0000;

    hdlc_tx_frame_loader #(.TIMEOUT(24'd100)) dut (
        .clk_100m      (clk_100m),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .tx_rd         (tx_rd),
        .tx_done       (tx_done),
        .trastart_flag (trastart_flag),
        .db            (db),
        .ramd          (ramd),
        .busy          (busy),
        .irq           (irq),
        .err           (err),
        .frm_cnt       (frm_cnt),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic emif_wr(input logic [23:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk_100m); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_rd();
        tx_rd = 1'b1;
        @(posedge clk_100m); #1;
        tx_rd = 1'b0;
        @(negedge clk_100m);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(posedge clk_100m); #1;
        tx_done = 1'b0;
        @(negedge clk_100m);
    endtask

    // Write LEN and GO, then wait (bounded) for the trastart pulse.
    task automatic launch(input logic [9:0] len, output bit found);
        emif_wr(A_LEN, {6'd0, len});
        emif_wr(A_GO, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_100m);
            if (trastart_flag) found = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit idle);
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk_100m);
            if (!busy && !irq) idle = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; tx_rd = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk_100m);
        checks++; if ({trastart_flag, busy, irq} !== 3'b000) begin failures++; $display("FAIL reset_ctl: got %b want 000", {trastart_flag, busy, irq}); end
        checks++; if (err !== 3'b000) begin failures++; $display("FAIL reset_err: got %b want 000", err); end
        checks++; if ({db, ramd} !== 18'd0) begin failures++; $display("FAIL reset_data: db=%0d ramd=%02h want 0", db, ramd); end
        checks++; if (frm_cnt !== 16'h0000) begin failures++; $display("FAIL reset_frm: got %0d want 0", frm_cnt); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk_100m);
    endtask

    task automatic test_basic_frame();
        bit found, idle;
        logic [7:0] exp_b;
        int ic;
        emif_wr(A_BUF + 24'd0, 16'h2211);
        emif_wr(A_BUF + 24'd1, 16'h4433);
        emif_wr(A_BUF + 24'd2, 16'h6655);
        emif_wr(A_BUF + 24'd3, 16'h8877);
        launch(10'd8, found);
        checks++; if (!found) begin failures++; $display("FAIL basic_start: no trastart_flag within 20 cycles"); end
        checks++; if (db !== 10'd8) begin failures++; $display("FAIL basic_db: got %0d want 8", db); end
        checks++; if (ramd !== 8'h11) begin failures++; $display("FAIL basic_byte0: got %02h want 11", ramd); end
        @(negedge clk_100m);
        checks++; if (trastart_flag !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_pulse: trastart=%b busy=%b want 0 1", trastart_flag, busy); end
        for (int k = 1; k < 8; k++) begin
            exp_b = 8'((k + 1) * 17);
            pulse_rd();
            checks++; if (ramd !== exp_b) begin failures++; $display("FAIL basic_byte%0d: got %02h want %02h", k, ramd, exp_b); end
        end
        pulse_rd();
        checks++; if (ramd !== 8'h00) begin failures++; $display("FAIL basic_past_end: got %02h want 00", ramd); end
        checks++; if (err !== 3'b000) begin failures++; $display("FAIL basic_err: got %b want 000", err); end
        pulse_done();
        checks++; if (busy !== 1'b1 || irq !== 1'b1) begin failures++; $display("FAIL basic_done: busy=%b irq=%b want 1 1", busy, irq); end
        ic = 1;
        @(negedge clk_100m);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
        if (irq) begin
            ic++;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_100m);
                if (irq) ic++;
                else break;
            end
        end
        checks++; if (ic !== 8) begin failures++; $display("FAIL basic_irq_width: got %0d want 8", ic); end
`ifdef HDLC_TX_FRMCNT_EN
        exp_frm = exp_frm + 16'd1;
`endif
        checks++; if (frm_cnt !== exp_frm) begin failures++; $display("FAIL basic_frm: got %0d want %0d", frm_cnt, exp_frm); end
        wait_idle(idle);
    endtask

    task automatic test_len_errors();
        bit found;
        launch(10'd0, found);
        checks++; if (found || busy) begin failures++; $display("FAIL len0_go: start=%b busy=%b want 0 0", found, busy); end
        checks++; if (err !== 3'b010) begin failures++; $display("FAIL len0_err: got %b want 010", err); end
        launch(10'd513, found);
        checks++; if (found || busy) begin failures++; $display("FAIL len513_go: start=%b busy=%b want 0 0", found, busy); end
        checks++; if (err !== 3'b010) begin failures++; $display("FAIL len513_err: got %b want 010", err); end
        emif_wr(A_GO, 16'h0002);
        @(negedge clk_100m);
        checks++; if (err !== 3'b000) begin failures++; $display("FAIL clear_err: got %b want 000", err); end
`ifdef HDLC_TX_FRMCNT_EN
        exp_frm = 16'h0000;
`endif
        checks++; if (frm_cnt !== exp_frm) begin failures++; $display("FAIL clear_frm: got %0d want %0d", frm_cnt, exp_frm); end
    endtask

    task automatic test_busy_violation();
        bit found, idle;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hBB; exp_b[1] = 8'hCC; exp_b[2] = 8'hDD; exp_b[3] = 8'h00;
        emif_wr(A_BUF + 24'd0, 16'hBBAA);
        emif_wr(A_BUF + 24'd1, 16'hDDCC);
        launch(10'd4, found);
        checks++; if (!found || ramd !== 8'hAA) begin failures++; $display("FAIL busy_start: found=%b ramd=%02h want 1 AA", found, ramd); end
        @(negedge clk_100m);
        emif_wr(A_GO, 16'h0001);
        emif_wr(A_BUF + 24'd1, 16'h0000);
        emif_wr(A_LEN, 16'h0002);
        @(negedge clk_100m);
        checks++; if (err !== 3'b001) begin failures++; $display("FAIL busy_err: got %b want 001", err); end
        checks++; if (db !== 10'd4 || busy !== 1'b1 || dbg_state !== SEND) begin failures++; $display("FAIL busy_hold: db=%0d busy=%b state=%0d want 4 1 SEND", db, busy, dbg_state); end
        for (int k = 0; k < 4; k++) begin
            pulse_rd();
            checks++; if (ramd !== exp_b[k]) begin failures++; $display("FAIL busy_byte%0d: got %02h want %02h", k + 1, ramd, exp_b[k]); end
        end
        pulse_done();
        wait_idle(idle);
        checks++; if (!idle) begin failures++; $display("FAIL busy_idle: frame did not return to idle"); end
`ifdef HDLC_TX_FRMCNT_EN
        exp_frm = exp_frm + 16'd1;
`endif
        checks++; if (frm_cnt !== exp_frm) begin failures++; $display("FAIL busy_frm: got %0d want %0d", frm_cnt, exp_frm); end
        emif_wr(A_GO, 16'h0002);
`ifdef HDLC_TX_FRMCNT_EN
        exp_frm = 16'h0000;
`endif
    endtask

    task automatic test_timeout();
        bit found, reached, idle;
        int sc;
        emif_wr(A_BUF + 24'd0, 16'h3C3C);
        launch(10'd2, found);
        checks++; if (!found) begin failures++; $display("FAIL to_start: no trastart_flag within 20 cycles"); end
        sc = 0; reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_100m);
            if (dbg_state == SEND) sc++;
            else begin
                reached = (dbg_state == DONE);
                break;
            end
        end
        checks++; if (!reached || sc !== 100) begin failures++; $display("FAIL to_cycles: done=%b send_cycles=%0d want 1 100", reached, sc); end
        checks++; if (err !== 3'b100 || irq !== 1'b1) begin failures++; $display("FAIL to_flags: err=%b irq=%b want 100 1", err, irq); end
        wait_idle(idle);
        checks++; if (!idle || frm_cnt !== exp_frm) begin failures++; $display("FAIL to_frm: idle=%b frm=%0d want 1 %0d", idle, frm_cnt, exp_frm); end
    endtask

    task automatic test_reset_mid_send();
        bit found, idle;
        emif_wr(A_BUF + 24'd0, 16'h1234);
        launch(10'd2, found);
        @(negedge clk_100m);
        pulse_rd();
        checks++; if (!found || ramd !== 8'h12) begin failures++; $display("FAIL rst_pre: found=%b ramd=%02h want 1 12", found, ramd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({trastart_flag, busy, irq, err} !== 6'd0 || {db, ramd} !== 18'd0 || frm_cnt !== 16'h0000)
            begin failures++; $display("FAIL rst_async: ts=%b busy=%b irq=%b err=%b db=%0d ramd=%02h frm=%0d want all 0", trastart_flag, busy, irq, err, db, ramd, frm_cnt); end
        exp_frm = 16'h0000;
        repeat (2) @(negedge clk_100m);
        rst_n = 1'b1;
        @(negedge clk_100m);
        emif_wr(A_BUF + 24'd0, 16'h5AA5);
        launch(10'd2, found);
        checks++; if (!found || db !== 10'd2 || ramd !== 8'hA5) begin failures++; $display("FAIL rst_relaunch: found=%b db=%0d ramd=%02h want 1 2 A5", found, db, ramd); end
        @(negedge clk_100m);
        pulse_rd();
        checks++; if (ramd !== 8'h5A) begin failures++; $display("FAIL rst_byte1: got %02h want 5A", ramd); end
        pulse_done();
        wait_idle(idle);
`ifdef HDLC_TX_FRMCNT_EN
        exp_frm = 16'd1;
`endif
        checks++; if (!idle || err !== 3'b000 || frm_cnt !== exp_frm) begin failures++; $display("FAIL rst_end: idle=%b err=%b frm=%0d want 1 000 %0d", idle, err, frm_cnt, exp_frm); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_len_errors();
        test_busy_violation();
        test_timeout();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
